fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives a single-outstanding-request instruction-memory port. It selects the next PC from the sequential, branch-redirect and trap sources, drops stale responses after a redirect, and presents fetched instructions to decode through a stall-aware output register. It sits between execute/trap logic and the decode stage and replaces the free-running PC register in the fetch stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept; holds the output instruction
- redirect_valid  in  1  branch/jump taken (execute)
- redirect_pc  in  32  branch/jump target
- trap_valid  in  1  trap/exception redirect
- trap_pc  in  32  trap vector
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction
- if_valid  out  1  if_instr/if_pc valid to decode
- if_instr  out  32  fetched instruction
- if_pc  out  32  PC of if_instr
- if_pcplus4  out  32  if_pc + 4 (combinational)

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only by reset; unconditionally to REQ on next clk.
- REQ: imem_req=1, imem_addr=pc. imem_req && imem_ready -> WAIT. Address may change while unaccepted (redirect).
- WAIT: imem_req=0. On imem_rvalid: if drop flag set -> clear drop, -> REQ, no output. Else if slot free (!if_valid || !stall) -> if_instr=imem_rdata, if_pc=pc, if_valid=1, pc<=pc+4, -> REQ. Else -> store in skid register (instr, pc), pc<=pc+4, -> HOLD.
- HOLD: imem_req=0. When !stall -> if_* loaded from skid, -> REQ.
- Consumption: if_valid && !stall in a cycle; if_valid clears next cycle unless refilled.
- Redirect: trap_valid has priority over redirect_valid; target = chosen pc with bits[1:0] forced to 00. Overrides stall. Next cycle: pc=target, if_valid=0, skid discarded. Destination: if a request is outstanding (WAIT without rvalid, or REQ accepted same cycle) -> WAIT with drop=1; if WAIT with rvalid same cycle -> response discarded, -> REQ; otherwise -> REQ.
- pc+4 wraps modulo 2^32.
- Only one request outstanding; at most one drop pending.

## Timing
- Reset (async assert): state=IDLE, pc=RESET_VECTOR, drop=0, imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, skid cleared.
- First imem_req: second rising edge after rst_n deasserts (IDLE->REQ).
- imem_req, imem_addr decoded from registered state/pc; no combinational path from imem_ready/rvalid to imem_req.
- Accept at edge N, rvalid at N+k (k>=1); if_valid visible after edge N+k; next request starts cycle N+k+1. Peak throughput: 1 instr / 2 cycles.
- Redirect sampled at edge N: new imem_addr visible after N; in-flight response dropped regardless of latency.
- Reset mid-WAIT: any later rvalid of the old request is ignored (state IDLE/REQ does not sample rvalid).

## Structure
- Shared package riscv_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD), RESET_VECTOR default, XLEN=32.
- Sub-module fetch_skid: one-entry instruction/pc buffer with load/clear/valid.
- Everything else flat in fetch_ctrl.

## Test plan
- Reset release, imem_ready=1, rvalid 1 cycle after accept, data=addr^0xA5A5A5A5 -> imem_addr 0,4,8 in REQ cycles 2,4,6; if_pc 0,4,8 with matching if_instr; if_pcplus4 = if_pc+4.
- stall=1 for 5 cycles after if_pc=4 -> if_* hold at 4; next response enters skid (pc 8), imem_req=0 in HOLD; stall release -> if_pc=8, then imem_addr=0xC.
- redirect_valid with redirect_pc=0x100 in WAIT (rvalid 3 cycles later) -> late response discarded, if_valid=0, next imem_addr=0x100, first if_pc=0x100.
- trap_valid(trap_pc=0x80) and redirect_valid(0x200) same cycle with stall=1 -> pc=0x80, if_valid=0, skid cleared; redirect_pc=0x203 later -> imem_addr=0x200.
- RESET_VECTOR=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- rst_n asserted mid-WAIT, rvalid pulsed during/after reset -> no if_valid, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch sequencer and its skid buffer.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction/pc buffer.
// Holds a response that arrives while decode is stalled.
module fetch_skid
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  if_id_t q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      q.instr  <= wr_instr;
      q.pc     <= wr_pc;
    end
  end

  assign instr = q.instr;
  assign pc    = q.pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one
// request at a time and feeds decode through a stall-aware register.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcplus4
);

  fetch_state_t state, state_n;

  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic            ifv_n;
  if_id_t          if_q, if_n;

  logic            redir;
  logic [XLEN-1:0] target;
  logic            busy;

  logic            skid_ld;
  logic            skid_clr;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_ld),
    .clear    (skid_clr),
    .wr_instr (imem_rdata),
    .wr_pc    (pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  assign redir  = trap_valid | redirect_valid;
  assign target = align4(trap_valid ? trap_pc : redirect_pc);

  // A request still in flight after this edge must be dropped.
  assign busy = ((state == WAIT) && !imem_rvalid) ||
                ((state == REQ) && imem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VECTOR;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_q     <= '0;
    end else begin
      pc       <= pc_n;
      drop     <= drop_n;
      if_valid <= ifv_n;
      if_q     <= if_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    drop_n   = drop;
    ifv_n    = if_valid && stall;
    if_n     = if_q;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    if (redir) begin
      pc_n     = target;
      ifv_n    = 1'b0;
      skid_clr = 1'b1;
      if (busy) begin
        state_n = WAIT;
        drop_n  = 1'b1;
      end else begin
        state_n = REQ;
        drop_n  = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_n = REQ;
        end
        REQ: begin
          if (imem_ready) begin
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            pc_n    = pc + 32'd4;
            state_n = REQ;
            if (drop) begin
              drop_n = 1'b0;
              pc_n   = pc;
            end else if (!if_valid || !stall) begin
              ifv_n      = 1'b1;
              if_n.instr = imem_rdata;
              if_n.pc    = pc;
            end else begin
              skid_ld = 1'b1;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            ifv_n      = 1'b1;
            if_n.instr = skid_instr;
            if_n.pc    = skid_pc;
            skid_clr   = 1'b1;
            state_n    = REQ;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign if_instr   = if_q.instr;
  assign if_pc      = if_q.pc;
  assign if_pcplus4 = if_q.pc + 32'd4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected fetch stream is
// rebuilt on every redirect/reset and checked against consumed output.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  bit mem_rand = 1'b0;
  int mem_lat = 1;

  logic [31:0] expq[$];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pcplus4     (if_pcplus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: sequential word addresses from the new target.
  task automatic restart(input logic [31:0] tgt);
    logic [31:0] a;
    a = tgt & 32'hFFFF_FFFC;
    expq.delete();
    for (int i = 0; i < 8; i++) expq.push_back(a + 32'(4 * i));
  endtask

  // Memory: one outstanding request, data = address ^ KEY.
  initial begin : mem
    int cnt;
    bit acc;
    logic [31:0] a, raddr;
    cnt = 0;
    raddr = '0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = imem_req && imem_ready;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (acc) begin
        cnt = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        raddr = a;
      end else if (cnt > 0) begin
        cnt--;
      end
      imem_rvalid = (cnt == 1);
      imem_rdata = imem_rvalid ? (raddr ^ KEY) : $urandom;
      imem_ready = (cnt == 0) && (mem_rand ? ($urandom % 4 != 0) : 1'b1);
    end
  end

  // Monitor: every consumed instruction must be the next expected one.
  initial begin : mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && !stall && !redirect_valid && !trap_valid) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %h expected none", if_pc);
        end else begin
          expq.push_back(expq[$] + 32'd4);
          e = expq.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, e ^ KEY);
          chk("sb_pcplus4", if_pcplus4, e + 32'd4);
          delivered++;
        end
      end
    end
  end

  initial begin : stim
    int d0;
    logic [31:0] t;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    trap_valid = 1'b0;
    trap_pc = '0;
    restart(32'h0);
    tick();
    tick();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);

    rst_n = 1'b1;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("wait_noreq", {31'b0, imem_req}, 32'd0);
    tick();
    chk("second_addr", imem_addr, 32'h4);
    chk("first_if_valid", {31'b0, if_valid}, 32'd1);
    chk("first_if_pc", if_pc, 32'h0);

    // Stall with pc 4 on the output; next response goes to the skid.
    for (int i = 0; i < 20 && !(if_valid && if_pc == 32'h4); i++) tick();
    chk("saw_pc4", if_pc, 32'h4);
    stall = 1'b1;
    repeat (5) tick();
    chk("stall_hold_pc", if_pc, 32'h4);
    chk("stall_hold_valid", {31'b0, if_valid}, 32'd1);
    chk("hold_noreq", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("skid_pc", if_pc, 32'h8);
    chk("after_hold_req", {31'b0, imem_req}, 32'd1);
    chk("after_hold_addr", imem_addr, 32'hC);

    // Redirect while a slow response is in flight.
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    restart(32'h100);
    tick();
    redirect_valid = 1'b0;
    chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_drop_wait", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    chk("redir_addr", imem_addr, 32'h100);

    // Trap beats redirect, overrides stall, discards the skid.
    mem_lat = 1;
    stall = 1'b1;
    repeat (12) tick();
    chk("pre_trap_valid", {31'b0, if_valid}, 32'd1);
    trap_valid = 1'b1;
    trap_pc = 32'h80;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    restart(32'h80);
    tick();
    trap_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("trap_if_valid", {31'b0, if_valid}, 32'd0);
    chk("trap_addr", imem_addr, 32'h80);
    tick();
    stall = 1'b0;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    restart(32'h203);
    tick();
    redirect_valid = 1'b0;
    chk("align_addr", imem_addr, 32'h200);

    // PC wraps modulo 2^32.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    restart(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    d0 = delivered;
    for (int i = 0; i < 60 && delivered < d0 + 3; i++) tick();
    chk("wrap_progress", {31'b0, delivered >= d0 + 3}, 32'd1);

    // Reset while a response is outstanding; it returns after release.
    mem_lat = 4;
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    restart(32'h0);
    #1;
    chk("areset_valid", {31'b0, if_valid}, 32'd0);
    chk("areset_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    mem_lat = 1;
    d0 = delivered;
    for (int i = 0; i < 60 && delivered < d0 + 3; i++) tick();
    chk("reset_progress", {31'b0, delivered >= d0 + 3}, 32'd1);

    // Randomized traffic.
    mem_rand = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom % 3 == 0);
      case ($urandom % 50)
        0: begin
          trap_valid = 1'b1;
          trap_pc = $urandom;
          redirect_valid = $urandom % 2 == 1;
          redirect_pc = $urandom;
          restart(trap_pc);
        end
        1: begin
          redirect_valid = 1'b1;
          t = $urandom;
          redirect_pc = t;
          restart(t);
        end
        default: ;
      endcase
      tick();
      trap_valid = 1'b0;
      redirect_valid = 1'b0;
    end
    stall = 1'b0;
    repeat (20) tick();
    chk("random_progress", {31'b0, delivered > d0 + 300}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
